// File: rtl/xge_pause_tx_gen_pkg.sv
// Shared definitions for the transmit-side PAUSE generator.
// Holds the MAC-control constants used to build the frame, the TX FSM
// encoding, the tuser field layout and the function that assembles one
// 64-bit beat of the generated 60-byte frame. The FCS is added by the MAC.
package xge_pause_tx_gen_pkg;

  localparam logic [47:0] PAUSE_DA           = 48'h0180C2000001;
  localparam logic [15:0] ETHERTYPE_MAC_CTRL = 16'h8808;
  localparam logic [15:0] OPCODE_PAUSE       = 16'h0001;

  // tuser layout: [2:0] valid bytes in the last beat (0 means 8), [3] error
  localparam int TUSER_NBYTES_LSB = 0;
  localparam int TUSER_NBYTES_W   = 3;
  localparam int TUSER_ERR        = 3;

  localparam logic [2:0] PAUSE_LAST_BEAT  = 3'd7;
  // 60 bytes = 7 full beats + 4 bytes; error bit clear
  localparam logic [3:0] PAUSE_LAST_TUSER = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_USER  = 2'd1,
    ST_PAUSE = 2'd2
  } tx_state_t;

  // First byte on the wire sits in [63:56].
  function automatic logic [63:0] pause_beat(input logic [2:0]  beat,
                                             input logic [47:0] src_mac,
                                             input logic [15:0] quanta);
    case (beat)
      3'd0:    return {PAUSE_DA, src_mac[47:32]};
      3'd1:    return {src_mac[31:0], ETHERTYPE_MAC_CTRL, OPCODE_PAUSE};
      3'd2:    return {quanta, 48'h0};
      default: return 64'h0;
    endcase
  endfunction

endpackage

// File: rtl/xge_pause_event_ctrl.sv
// Pause event controller.
// Turns the xoff level into pending PAUSE requests: rising edge requests an
// XOFF, falling edge requests an XON (or cancels an unsent XOFF), and a
// refresh timer re-requests XOFF while xoff stays high after an XOFF frame.
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   pause_en        0 blocks new events and drops any pending request
//   xoff            level request from the local receive buffer
//   pend_take       the TX FSM has latched the pending request
//   frame_done      last beat of a generated frame transferred
//   frame_xoff      the completing frame carried non-zero quanta
//   pend            a PAUSE frame is pending
//   pend_quanta     quanta for the pending frame (latest event wins)
module xge_pause_event_ctrl #(
  parameter logic [15:0] PAUSE_QUANTA   = 16'hFFFF,
  parameter logic [31:0] REFRESH_CYCLES = 32'd40000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pause_en,
  input  logic        xoff,
  input  logic        pend_take,
  input  logic        frame_done,
  input  logic        frame_xoff,
  output logic        pend,
  output logic [15:0] pend_quanta
);

  logic        xoff_q;
  logic        xoff_sent;
  logic        refresh_armed;
  logic [31:0] timer;
  logic        rise, fall, refresh_due;

  always_comb begin
    rise        = pause_en && xoff && !xoff_q;
    fall        = pause_en && !xoff && xoff_q;
    // Armed only by a completed XOFF so that the timer fires once per load.
    refresh_due = pause_en && xoff_q && refresh_armed && (timer == 32'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xoff_q        <= 1'b0;
      xoff_sent     <= 1'b0;
      refresh_armed <= 1'b0;
      timer         <= 32'd0;
      pend          <= 1'b0;
    end else begin
      xoff_q <= xoff;

      if (frame_done && frame_xoff) begin
        timer         <= REFRESH_CYCLES - 32'd1;
        refresh_armed <= 1'b1;
      end else if (frame_done || refresh_due) begin
        refresh_armed <= 1'b0;
      end else if (pause_en && xoff_q && (timer != 32'd0)) begin
        timer <= timer - 32'd1;
      end

      if (frame_done) xoff_sent <= frame_xoff;

      // Later assignments take priority: a new event beats the FSM's take,
      // and pause_en low beats everything.
      if (pend_take)   pend <= 1'b0;
      if (refresh_due) pend <= 1'b1;
      if (rise)        pend <= 1'b1;
      if (fall)        pend <= xoff_sent;
      if (!pause_en)   pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (refresh_due || rise)       pend_quanta <= PAUSE_QUANTA;
    if (fall && xoff_sent)         pend_quanta <= 16'h0;
  end

endmodule

// File: rtl/xge_pause_tx_gen.sv
// Transmit-side IEEE 802.3x PAUSE generator on the 64-bit AXI4-S TX path.
// User frames pass through with zero latency; pending PAUSE frames are
// inserted only between user frames as 8-beat, 60-byte MAC control frames.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   pause_en, xoff          pause enable and local flow-control request
//   in_t*                   user AXI4-S stream (tuser: [2:0] bytes, [3] err)
//   out_t*                  stream towards the AXI-to-XGE adapter
//   pause_frames_sent       wrapping count of completed generated frames
module xge_pause_tx_gen
  import xge_pause_tx_gen_pkg::*;
#(
  parameter logic [47:0] SRC_MAC        = 48'h00_80_2F_00_00_00,
  parameter logic [15:0] PAUSE_QUANTA   = 16'hFFFF,
  parameter logic [31:0] REFRESH_CYCLES = 32'd40000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pause_en,
  input  logic        xoff,
  input  logic [63:0] in_tdata,
  input  logic [3:0]  in_tuser,
  input  logic        in_tlast,
  input  logic        in_tvalid,
  output logic        in_tready,
  output logic [63:0] out_tdata,
  output logic [3:0]  out_tuser,
  output logic        out_tlast,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic [15:0] pause_frames_sent
);

  tx_state_t   state;
  logic [2:0]  beat;
  logic [15:0] cur_quanta;
  logic        pend;
  logic [15:0] pend_quanta;
  logic        pend_take, passthru, user_xfer, frame_done, frame_xoff;

  xge_pause_event_ctrl #(
    .PAUSE_QUANTA   (PAUSE_QUANTA),
    .REFRESH_CYCLES (REFRESH_CYCLES)
  ) u_event_ctrl (
    .clk         (clk),
    .reset_n     (reset_n),
    .pause_en    (pause_en),
    .xoff        (xoff),
    .pend_take   (pend_take),
    .frame_done  (frame_done),
    .frame_xoff  (frame_xoff),
    .pend        (pend),
    .pend_quanta (pend_quanta)
  );

  always_comb begin
    pend_take  = (state == ST_IDLE) && pend && pause_en;
    // The IDLE cycle that takes a request blocks the user side.
    passthru   = reset_n && ((state == ST_USER) || ((state == ST_IDLE) && !pend_take));
    user_xfer  = passthru && in_tvalid && out_tready;
    frame_done = (state == ST_PAUSE) && out_tready && (beat == PAUSE_LAST_BEAT);
    frame_xoff = (cur_quanta != 16'h0);
  end

  always_comb begin
    in_tready  = 1'b0;
    out_tdata  = 64'h0;
    out_tuser  = 4'h0;
    out_tlast  = 1'b0;
    out_tvalid = 1'b0;
    if (passthru) begin
      in_tready  = out_tready;
      out_tdata  = in_tdata;
      out_tuser  = in_tuser;
      out_tlast  = in_tlast;
      out_tvalid = in_tvalid;
    end else if (state == ST_PAUSE) begin
      out_tvalid = 1'b1;
      out_tdata  = pause_beat(beat, SRC_MAC, cur_quanta);
      out_tlast  = (beat == PAUSE_LAST_BEAT);
      if (beat == PAUSE_LAST_BEAT) out_tuser = PAUSE_LAST_TUSER;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      beat              <= 3'd0;
      pause_frames_sent <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pend_take) begin
            beat  <= 3'd0;
            state <= ST_PAUSE;
          end else if (user_xfer && !in_tlast) begin
            state <= ST_USER;
          end
        end
        ST_USER: begin
          if (user_xfer && in_tlast) state <= ST_IDLE;
        end
        ST_PAUSE: begin
          if (out_tready) begin
            if (beat == PAUSE_LAST_BEAT) begin
              pause_frames_sent <= pause_frames_sent + 16'd1;
              state             <= ST_IDLE;
            end else begin
              beat <= beat + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pend_take) cur_quanta <= pend_quanta;
  end

endmodule
